// File: rtl/i2c_slave_module.sv
// i2c_slave_module: 7-bit I2C responder oversampled on i_sysclk (>= 16x SCL).
// Define I2C_SLV_GENERAL_CALL_EN to also accept the general-call write (address 0x00).
module i2c_slave_module #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       scl_pin,
    inout  wire        sda_pin,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_req,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_busy,
    output logic       o_addr_match,
    output logic       o_rw,
    output logic       o_nack
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       fall_d, slot, sda_oe;
    logic [3:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] tx_shreg;
    logic [7:0] byte_nx;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       addr_hit, gc_hit;

    // Synchronizers run through reset so no false edge appears on release
    always_ff @(posedge i_sysclk) begin
        scl_s1 <= scl_pin;
        scl_s2 <= scl_s1;
        scl_d  <= scl_s2;
        sda_s1 <= sda_pin;
        sda_s2 <= sda_s1;
        sda_d  <= sda_s2;
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign byte_nx   = {shreg, sda_s2};

`ifdef I2C_SLV_GENERAL_CALL_EN
    assign gc_hit = (byte_nx == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif

    assign addr_hit = (byte_nx[7:1] == SLAVE_ADDR) || gc_hit;
    assign sda_pin  = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            state        <= IDLE;
            fall_d       <= 1'b0;
            slot         <= 1'b0;
            sda_oe       <= 1'b0;
            bit_cnt      <= 4'd0;
            shreg        <= 7'd0;
            tx_shreg     <= 8'd0;
            o_tx_req     <= 1'b0;
            o_rx_data    <= 8'd0;
            o_rx_valid   <= 1'b0;
            o_start      <= 1'b0;
            o_stop       <= 1'b0;
            o_busy       <= 1'b0;
            o_addr_match <= 1'b0;
            o_rw         <= 1'b0;
            o_nack       <= 1'b0;
        end else begin
            o_start    <= start_det;
            o_stop     <= stop_det;
            o_tx_req   <= 1'b0;
            o_rx_valid <= 1'b0;
            o_nack     <= 1'b0;
            fall_d     <= scl_fall;
            if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= 4'd0;
                slot         <= 1'b0;
                sda_oe       <= 1'b0;
                o_busy       <= 1'b1;
                o_addr_match <= 1'b0;
            end else if (stop_det) begin
                state        <= IDLE;
                bit_cnt      <= 4'd0;
                slot         <= 1'b0;
                sda_oe       <= 1'b0;
                o_busy       <= 1'b0;
                o_addr_match <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, IGNORE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= byte_nx[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                slot <= 1'b0;
                                if (addr_hit) begin
                                    state <= ADDR_ACK;
                                    o_rw  <= byte_nx[0];
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    // slot=0: waiting for the fall ending bit 8; slot=1: ACK bit on the bus
                    ADDR_ACK: begin
                        if (scl_rise && slot && o_rw)
                            o_tx_req <= 1'b1;
                        if (scl_fall && slot)
                            tx_shreg <= i_tx_data;
                        if (fall_d) begin
                            if (!slot) begin
                                sda_oe       <= 1'b1;
                                slot         <= 1'b1;
                                o_addr_match <= 1'b1;
                            end else begin
                                slot     <= 1'b0;
                                bit_cnt  <= 4'd0;
                                sda_oe   <= o_rw ? ~tx_shreg[7] : 1'b0;
                                tx_shreg <= {tx_shreg[6:0], 1'b0};
                                state    <= o_rw ? TX : RX;
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shreg   <= byte_nx[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                o_rx_data  <= byte_nx;
                                o_rx_valid <= 1'b1;
                                slot       <= 1'b0;
                                state      <= RX_ACK;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (fall_d) begin
                            if (!slot) begin
                                sda_oe <= 1'b1;
                                slot   <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                slot    <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RX;
                            end
                        end
                    end
                    TX: begin
                        if (scl_rise)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (fall_d) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                slot   <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe   <= ~tx_shreg[7];
                                tx_shreg <= {tx_shreg[6:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                o_tx_req <= 1'b1;
                                slot     <= 1'b1;
                            end else begin
                                o_nack <= 1'b1;
                                state  <= IGNORE;
                            end
                        end
                        if (scl_fall && slot)
                            tx_shreg <= i_tx_data;
                        if (fall_d && slot) begin
                            sda_oe   <= ~tx_shreg[7];
                            tx_shreg <= {tx_shreg[6:0], 1'b0};
                            bit_cnt  <= 4'd0;
                            slot     <= 1'b0;
                            state    <= TX;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_slave_module.md
I2C_SLAVE_MODULE -- requirements
Module: i2c_slave_module

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this responder answers to.
REQ-002 SHALL have port i_sysclk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port scl_pin, input, 1 bit: the I2C clock pad; this block never stretches SCL.
REQ-005 SHALL have port sda_pin, inout, 1 bit: the open-drain data pad, driven 1'b0 or high-Z only.
REQ-006 SHALL have port i_tx_data, input, 8 bits: the read byte to send to the master.
REQ-007 SHALL have port o_tx_req, output, 1 bit: one-cycle pulse requesting the next read byte.
REQ-008 SHALL have port o_rx_data, output, 8 bits: the last byte written by the master.
REQ-009 SHALL have port o_rx_valid, output, 1 bit: one-cycle pulse meaning o_rx_data is new.
REQ-010 SHALL have ports o_start and o_stop, outputs, 1 bit each: one-cycle pulses on START/repeated START and on STOP.
REQ-011 SHALL have port o_busy, output, 1 bit: high from START until STOP.
REQ-012 SHALL have port o_addr_match, output, 1 bit: high from the address ACK until the next START or STOP.
REQ-013 SHALL have port o_rw, output, 1 bit: the R/W bit of the matched address byte (1 = read).
REQ-014 SHALL have port o_nack, output, 1 bit: one-cycle pulse when the master NACKs a read byte.

Function
REQ-015 SHALL pass SCL and SDA through 2-flop synchronizers; all edge and condition detection uses the synchronized values.
REQ-016 SHALL require i_sysclk to be at least 16x the SCL frequency.
REQ-017 SHALL detect START (including repeated START) as synchronized SDA falling while SCL is high; o_start pulses 1 cycle after detection.
REQ-018 SHALL detect STOP as synchronized SDA rising while SCL is high; o_stop pulses 1 cycle after detection.
REQ-019 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
REQ-020 SHALL enter ADDR on START from any state; a START takes priority over every other event in the same cycle.
REQ-021 SHALL enter IDLE on STOP from any state and release SDA on the next cycle.
REQ-022 SHALL shift bits MSB first, sampling SDA on each synchronized SCL rising edge.
REQ-023 SHALL leave ADDR after 8 bits: on address match go to ADDR_ACK; on mismatch go to IGNORE and never drive SDA.
REQ-024 SHALL change SDA only 1 cycle after a detected SCL falling edge, to guarantee hold time.
REQ-025 SHALL, in ADDR_ACK, drive SDA low for one SCL period, then go to TX if R/W=1, otherwise RX.
REQ-026 SHALL, after the 8th bit of an RX byte, pulse o_rx_valid 1 cycle after the sampling SCL rise, then ACK in RX_ACK; the number of bytes written is unlimited.
REQ-027 SHALL pulse o_tx_req on the SCL rise of the address ACK slot, and again on each TX_ACK rise where the master ACKs (SDA=0).
REQ-028 SHALL latch i_tx_data on the SCL falling edge that ends that ACK slot.
REQ-029 SHALL drive SDA low for 0 bits and release it for 1 bits during TX.
REQ-030 SHALL release SDA in TX_ACK; if the master NACKs (SDA=1), pulse o_nack and go to IGNORE until START or STOP.
REQ-031 SHALL treat SDA changes while SCL is low as data, not as conditions.

Reset
REQ-032 SHALL, while i_reset is high, force state IDLE and release sda_pin (high-Z).
REQ-033 SHALL, while i_reset is high, force all outputs and shift/bit counters to 0.
REQ-034 SHALL, after a reset mid-transfer, ignore the bus until the next START.

Configuration
REQ-035 SHALL, when I2C_SLV_GENERAL_CALL_EN is defined, also accept address 7'h00 with R/W=0 (ACK, then RX).
REQ-036 SHALL, when I2C_SLV_GENERAL_CALL_EN is undefined, treat address 7'h00 as a mismatch (go to IGNORE).

Verification
REQ-037 Master writes address 0xA0 then 0x5A, 0xC3, then STOP -> both address and data are ACKed, o_rx_valid pulses twice with 0x5A then 0xC3, and o_stop pulses once.
REQ-038 Master sends address 0xA1 with i_tx_data=0x96, master NACKs -> bits on SDA are 1001_0110, o_tx_req pulses once, and o_nack pulses.
REQ-039 Master sends address 0xA2 -> SDA is never driven low, no rx/tx pulses occur, and o_busy falls at STOP.
REQ-040 Write 0xA0, 0x01, repeated START, then 0xA1 read of 2 bytes (ACK then NACK) -> o_start pulses twice, o_tx_req pulses twice, o_rw=1.
REQ-041 Assert i_reset mid-RX byte -> SDA is released the next cycle, all outputs are 0, and the next full transaction completes correctly.
REQ-042 Address 0x00 write -> ACKed only with I2C_SLV_GENERAL_CALL_EN defined, otherwise ignored.
